// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types and constants for the UART MVM frame sequencer
// Contents: sequencer state enum, default geometry, derived frame byte counts.
package mvm_pkg;

    localparam int DEF_R             = 4;
    localparam int DEF_C             = 4;
    localparam int DEF_W_K           = 4;
    localparam int DEF_W_X           = 4;
    localparam int DEF_W_Y_OUT       = 16;
    localparam int DEF_BITS_PER_WORD = 8;
    localparam int DEF_TIMEOUT       = 1024;

    // Bytes in one input frame (K row-major, then X) and one result frame.
    localparam int N_IN_BYTES  = DEF_R * DEF_C + DEF_C;
    localparam int N_OUT_BYTES = DEF_R * DEF_W_Y_OUT / 8;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } seq_state_t;

    function automatic int n_in_bytes(input int r, input int c);
        return r * c + c;
    endfunction

    function automatic int n_out_bytes(input int r, input int w_y, input int bpw);
        return r * w_y / bpw;
    endfunction

endpackage

// File: rtl/mvm_seq_tx_ser.sv
// rtl/mvm_seq_tx_ser.sv - result buffer and LSB-first byte serializer
// Ports: clk, rstn (async active-low), load (capture y_flat), y_flat (results),
//        accept (current byte taken by transmitter), m_data (current byte),
//        done (combinational: accept of the last byte this cycle).
module mvm_seq_tx_ser import mvm_pkg::*; #(
    parameter int R             = DEF_R,
    parameter int W_Y_OUT       = DEF_W_Y_OUT,
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load,
    input  logic [R*W_Y_OUT-1:0]     y_flat,
    input  logic                     accept,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     done
);

    localparam int N_OUT = n_out_bytes(R, W_Y_OUT, BITS_PER_WORD);
    localparam int BW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [R*W_Y_OUT-1:0] buf_q;
    logic [BW-1:0]        byte_idx;

    // The buffer is shifted down as bytes go out, so the current byte is
    // always the bottom slice; byte_idx only tracks where the frame ends.
    assign m_data = buf_q[BITS_PER_WORD-1:0];
    assign done   = accept && (byte_idx == BW'(N_OUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            buf_q    <= y_flat;
            byte_idx <= '0;
        end else if (accept) begin
            buf_q    <= buf_q >> BITS_PER_WORD;
            byte_idx <= done ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - frame sequencer between UART byte streams and the MVM core
// Ports: clk, rstn (async active-low); s_data/s_valid/s_ready (received bytes);
//        k_flat/x_flat (operands); mvm_valid/mvm_ready (start handshake);
//        y_flat/y_valid (results); m_data/m_valid/m_ready (bytes to transmit);
//        frame_done (pulse after last result byte).
// Option: MVM_SEQ_TIMEOUT_EN enables the inter-byte gap timeout in LOAD.
module mvm_seq_ctrl import mvm_pkg::*; #(
    parameter int R              = DEF_R,
    parameter int C              = DEF_C,
    parameter int W_K            = DEF_W_K,
    parameter int W_X            = DEF_W_X,
    parameter int W_Y_OUT        = DEF_W_Y_OUT,
    parameter int BITS_PER_WORD  = DEF_BITS_PER_WORD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [BITS_PER_WORD-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [R*C*W_K-1:0]       k_flat,
    output logic [C*W_X-1:0]         x_flat,
    output logic                     mvm_valid,
    input  logic                     mvm_ready,
    input  logic [R*W_Y_OUT-1:0]     y_flat,
    input  logic                     y_valid,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     frame_done
);

    localparam int N_KB = R * C;
    localparam int N_IN = n_in_bytes(R, C);
    localparam int CW   = $clog2(N_IN);

    if ((W_Y_OUT % BITS_PER_WORD) != 0 || TIMEOUT_CYCLES < 1
        || W_K > BITS_PER_WORD || W_X > BITS_PER_WORD) begin : g_bad_cfg
        $error("mvm_seq_ctrl: unsupported parameter combination");
    end

    seq_state_t state, state_nxt;

    logic [CW-1:0]       byte_cnt;
    logic [R*C*W_K-1:0]  k_q;
    logic [C*W_X-1:0]    x_q;
    logic                s_fire;
    logic                last_in;
    logic                m_fire;
    logic                tx_done;
    logic                tx_load;
    logic                unused_s_data;

    // Only the low element bits of each byte are kept.
    assign unused_s_data = ^s_data;

    assign s_fire  = s_valid && s_ready;
    assign last_in = s_fire && (byte_cnt == CW'(N_IN - 1));
    assign m_fire  = m_valid && m_ready;
    assign tx_load = (state == S_WAIT) && y_valid;
    assign k_flat  = k_q;
    assign x_flat  = x_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are pure decodes of the state register, so none of
    // them depends combinationally on an input.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        mvm_valid = 1'b0;
        m_valid   = 1'b0;
        case (state)
            S_LOAD: begin
                s_ready = 1'b1;
                if (last_in) state_nxt = S_START;
            end
            S_START: begin
                mvm_valid = 1'b1;
                if (mvm_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (y_valid) state_nxt = S_SEND;
            end
            S_SEND: begin
                m_valid = 1'b1;
                if (tx_done) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

`ifdef MVM_SEQ_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    logic [GW-1:0] gap_cnt;
    logic          gap_active;
    logic          timeout_hit;

    // The gap only matters once a frame has started arriving.
    assign gap_active  = (state == S_LOAD) && (byte_cnt != '0) && !s_fire;
    assign timeout_hit = gap_active && (gap_cnt == GW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_cnt <= '0;
        end else if (!gap_active || timeout_hit) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
        end else if (s_fire) begin
            byte_cnt <= last_in ? '0 : byte_cnt + 1'b1;
        end
`ifdef MVM_SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
            byte_cnt <= '0;
        end
`endif
    end

    // Operand registers are only written by accepted bytes; a discarded
    // partial frame leaves its elements behind until the next frame lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q <= '0;
            x_q <= '0;
        end else if (s_fire) begin
            for (int i = 0; i < N_KB; i++) begin
                if (byte_cnt == CW'(i)) k_q[i*W_K +: W_K] <= s_data[W_K-1:0];
            end
            for (int i = 0; i < C; i++) begin
                if (byte_cnt == CW'(N_KB + i)) x_q[i*W_X +: W_X] <= s_data[W_X-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= tx_done;
        end
    end

    mvm_seq_tx_ser #(
        .R             (R),
        .W_Y_OUT       (W_Y_OUT),
        .BITS_PER_WORD (BITS_PER_WORD)
    ) u_tx_ser (
        .clk    (clk),
        .rstn   (rstn),
        .load   (tx_load),
        .y_flat (y_flat),
        .accept (m_fire),
        .m_data (m_data),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - self-checking bench for mvm_seq_ctrl
module tb_mvm_seq_ctrl;
    import mvm_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] k_flat;
    logic [15:0] x_flat;
    logic        mvm_valid;
    logic        mvm_ready;
    logic [63:0] y_flat;
    logic        y_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  fb [N_IN_BYTES];
    logic [63:0] exp_k;
    logic [15:0] exp_x;
    logic [7:0]  exp_bytes [$];

    always #5 clk = ~clk;

    mvm_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .k_flat     (k_flat),
        .x_flat     (x_flat),
        .mvm_valid  (mvm_valid),
        .mvm_ready  (mvm_ready),
        .y_flat     (y_flat),
        .y_valid    (y_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected operands: element (r,c) takes the low nibble of byte r*4+c,
    // X element c the low nibble of byte 16+c.
    task automatic build_model();
        exp_k = '0;
        exp_x = '0;
        for (int i = 0; i < 16; i++) exp_k[i*4 +: 4] = fb[i][3:0];
        for (int i = 0; i < 4; i++)  exp_x[i*4 +: 4] = fb[16+i][3:0];
    endtask

    // Results y[r] = sum_c K(r,c)*X(c), signed, then LSB-first bytes.
    task automatic build_results();
        int acc;
        logic [15:0] yr;
        exp_bytes.delete();
        y_flat = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++)
                acc += int'($signed(fb[r*4+c][3:0])) * int'($signed(fb[16+c][3:0]));
            yr = acc[15:0];
            y_flat[r*16 +: 16] = yr;
            exp_bytes.push_back(yr[7:0]);
            exp_bytes.push_back(yr[15:8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("s_ready_timeout", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < N_IN_BYTES; i++) begin
            send_byte(fb[i]);
            if (i < N_IN_BYTES - 1) chk("mvm_valid_early", {63'd0, mvm_valid}, 64'd0);
        end
        chk("mvm_valid_after_last", {63'd0, mvm_valid}, 64'd1);
        chk("s_ready_start", {63'd0, s_ready}, 64'd0);
        chk("k_flat", k_flat, exp_k);
        chk("x_flat", {48'd0, x_flat}, {48'd0, exp_x});
    endtask

    task automatic start_mvm(input int hold);
        mvm_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("mvm_valid_hold", {63'd0, mvm_valid}, 64'd1);
            chk("k_flat_hold", k_flat, exp_k);
            chk("x_flat_hold", {48'd0, x_flat}, {48'd0, exp_x});
            chk("s_ready_hold", {63'd0, s_ready}, 64'd0);
        end
        mvm_ready = 1'b1;
        tick();
        mvm_ready = 1'b0;
        chk("mvm_valid_cleared", {63'd0, mvm_valid}, 64'd0);
    endtask

    task automatic return_results();
        int idx = 0;
        int cyc = 0;
        build_results();
        tick();
        tick();
        chk("m_valid_in_wait", {63'd0, m_valid}, 64'd0);
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        y_flat  = '0;
        while (idx < N_OUT_BYTES && cyc < 400) begin
            m_ready = 1'($urandom_range(0, 1));
            chk("m_valid_send", {63'd0, m_valid}, 64'd1);
            chk("m_data", {56'd0, m_data}, {56'd0, exp_bytes[idx]});
            if (m_ready) idx++;
            tick();
            cyc++;
            if (idx < N_OUT_BYTES) chk("frame_done_early", {63'd0, frame_done}, 64'd0);
        end
        m_ready = 1'b0;
        chk("all_bytes_sent", 64'(idx), 64'(N_OUT_BYTES));
        chk("frame_done_pulse", {63'd0, frame_done}, 64'd1);
        chk("s_ready_after_frame", {63'd0, s_ready}, 64'd1);
        chk("m_valid_after_frame", {63'd0, m_valid}, 64'd0);
        tick();
        chk("frame_done_single", {63'd0, frame_done}, 64'd0);
    endtask

    task automatic random_frame();
        for (int i = 0; i < N_IN_BYTES; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        rstn = 1'b0; s_data = '0; s_valid = 1'b0; mvm_ready = 1'b0;
        y_flat = '0; y_valid = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("rst_mvm_valid", {63'd0, mvm_valid}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_m_data", {56'd0, m_data}, 64'd0);
        chk("rst_k_flat", k_flat, 64'd0);
        chk("rst_x_flat", {48'd0, x_flat}, 64'd0);

        // Frame 1: K(r,c)=r+c, X=1 -> y = 6,10,14,18
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) fb[r*4+c] = 8'(r + c);
        for (int c = 0; c < 4; c++) fb[16+c] = 8'd1;
        build_model();
        chk("model_x_1111", {48'd0, exp_x}, 64'h1111);
        send_frame();
        start_mvm(5);
        return_results();
        chk("frame1_bytes", {exp_bytes[0], exp_bytes[1], exp_bytes[2], exp_bytes[3],
                             exp_bytes[4], exp_bytes[5], exp_bytes[6], exp_bytes[7]},
            64'h06000A000E001200);

        // Stray y_valid in LOAD must not start transmission
        y_flat  = 64'hDEAD_BEEF_1234_5678;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        y_flat  = '0;
        chk("stray_y_m_valid", {63'd0, m_valid}, 64'd0);
        tick();
        chk("stray_y_m_valid2", {63'd0, m_valid}, 64'd0);
        chk("stray_y_s_ready", {63'd0, s_ready}, 64'd1);

        // Frame 2: random bytes, first byte 0xF7 (upper bits ignored)
        random_frame();
        fb[0] = 8'hF7;
        build_model();
        send_frame();
        chk("k00_low_nibble", {60'd0, k_flat[3:0]}, 64'h7);
        start_mvm(0);
        return_results();

        // Mid-frame reset: first 10 bytes must be discarded
        random_frame();
        for (int i = 0; i < 10; i++) send_byte(fb[i]);
        rstn = 1'b0;
        #1;
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("midrst_mvm_valid", {63'd0, mvm_valid}, 64'd0);
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_k_flat", k_flat, 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        random_frame();
        build_model();
        send_frame();
        start_mvm(2);
        return_results();

`ifdef MVM_SEQ_TIMEOUT_EN
        // Partial frame abandoned by the gap timeout
        random_frame();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        for (int i = 0; i < 16; i++) tick();
        chk("timeout_idle_mvm_valid", {63'd0, mvm_valid}, 64'd0);
        build_model();
        send_frame();
        start_mvm(1);
        return_results();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $error("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
